// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S RAM access path: arbiter FSM states and requester identities.
package k_and_s_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
    typedef enum logic {REQ_CORE, REQ_DBG} requester_t;

    localparam int unsigned REQ_N = 2;

    function automatic requester_t other_requester(input requester_t r);
        return (r == REQ_CORE) ? REQ_DBG : REQ_CORE;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between core and debug, with optional debug-wins-ties override.
module rr_arbiter2
    import k_and_s_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  requester_t       last_winner,
    input  logic             dbg_priority,
    output logic             grant_valid_c,
    output requester_t       winner_c
);

    always_comb begin
        grant_valid_c = |req;
        winner_c      = REQ_CORE;
        if (req == 2'b11) begin
            winner_c = dbg_priority ? REQ_DBG : other_requester(last_winner);
        end else if (req[1]) begin
            winner_c = REQ_DBG;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Sequences single-port RAM accesses from the core and the debug port as one
// multi-cycle transaction at a time, each ending with a one-cycle done pulse.
module ram_access_arbiter
    import k_and_s_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_priority,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned      CNT_W    = $clog2(RAM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_LATENCY - 1);

    arb_state_t        state_q, state_d;
    requester_t        winner_q, winner_d;
    requester_t        last_winner_q, last_winner_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              core_done_q, core_done_d;
    logic              dbg_done_q, dbg_done_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              busy_q, busy_d;

    logic              grant_valid_c;
    requester_t        pick_c;

    rr_arbiter2 u_rr_arbiter2 (
        .req           ({dbg_req, core_req}),
        .last_winner   (last_winner_q),
        .dbg_priority  (dbg_priority),
        .grant_valid_c (grant_valid_c),
        .winner_c      (pick_c)
    );

    // Outputs are registered, so each is computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        last_winner_d = last_winner_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        ram_we_d      = 1'b0;
        core_done_d   = 1'b0;
        dbg_done_d    = 1'b0;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid_c) begin
                    winner_d      = pick_c;
                    last_winner_d = pick_c;
                    if (pick_c == REQ_DBG) begin
                        we_d        = dbg_we;
                        ram_addr_d  = dbg_addr;
                        ram_wdata_d = dbg_wdata;
                    end else begin
                        we_d        = core_we;
                        ram_addr_d  = core_addr;
                        ram_wdata_d = core_wdata;
                    end
                    ram_we_d = we_d;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (we_q) begin
                    state_d     = ARB_DONE;
                    core_done_d = (winner_q == REQ_CORE);
                    dbg_done_d  = (winner_q == REQ_DBG);
                end else begin
                    state_d = ARB_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    if (winner_q == REQ_DBG) begin
                        dbg_rdata_d = ram_rdata;
                    end else begin
                        core_rdata_d = ram_rdata;
                    end
                    state_d     = ARB_DONE;
                    core_done_d = (winner_q == REQ_CORE);
                    dbg_done_d  = (winner_q == REQ_DBG);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            winner_q      <= REQ_CORE;
            last_winner_q <= REQ_DBG;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_we_q      <= 1'b0;
            core_done_q   <= 1'b0;
            dbg_done_q    <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_we_q      <= ram_we_d;
            core_done_q   <= core_done_d;
            dbg_done_q    <= dbg_done_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign core_done  = core_done_q;
    assign dbg_done   = dbg_done_q;
    assign core_rdata = core_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign busy       = busy_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Random-stimulus bench for ram_access_arbiter at RAM latencies 1 and 3, checked against a
// cycle-count transaction model of the arbitration and latency rules.
module tb_ram_access_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n      [NI];
    logic          core_req   [NI];
    logic          core_we    [NI];
    logic [AW-1:0] core_addr  [NI];
    logic [DW-1:0] core_wdata [NI];
    logic          core_done  [NI];
    logic [DW-1:0] core_rdata [NI];
    logic          dbg_req    [NI];
    logic          dbg_we     [NI];
    logic [AW-1:0] dbg_addr   [NI];
    logic [DW-1:0] dbg_wdata  [NI];
    logic          dbg_done   [NI];
    logic [DW-1:0] dbg_rdata  [NI];
    logic          dbg_prio;
    logic          busy       [NI];
    logic [AW-1:0] ram_addr   [NI];
    logic [DW-1:0] ram_wdata  [NI];
    logic          ram_we     [NI];
    logic [DW-1:0] ram_rdata  [NI];
    logic [DW-1:0] ram_mem    [NI][32];

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int unsigned LAT = (gi == 0) ? 1 : 3;
        logic [AW-1:0] apipe [4];

        ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[gi]),
            .core_req     (core_req[gi]),
            .core_we      (core_we[gi]),
            .core_addr    (core_addr[gi]),
            .core_wdata   (core_wdata[gi]),
            .core_done    (core_done[gi]),
            .core_rdata   (core_rdata[gi]),
            .dbg_req      (dbg_req[gi]),
            .dbg_we       (dbg_we[gi]),
            .dbg_addr     (dbg_addr[gi]),
            .dbg_wdata    (dbg_wdata[gi]),
            .dbg_done     (dbg_done[gi]),
            .dbg_rdata    (dbg_rdata[gi]),
            .dbg_priority (dbg_prio),
            .busy         (busy[gi]),
            .ram_addr     (ram_addr[gi]),
            .ram_wdata    (ram_wdata[gi]),
            .ram_we       (ram_we[gi]),
            .ram_rdata    (ram_rdata[gi])
        );

        // RAM macro read path: data appears LAT cycles after the address.
        always @(posedge clk) begin
            apipe[0] <= ram_addr[gi];
            for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
        end
        assign ram_rdata[gi] = ram_mem[gi][apipe[LAT-1]];
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = -1;

    // Reference model state, one set per instance.
    bit            m_act   [NI];
    int            m_start [NI];
    int            m_done  [NI];
    int            m_who   [NI];
    bit            m_we    [NI];
    logic [AW-1:0] m_addr  [NI];
    logic [DW-1:0] m_wd    [NI];
    logic [DW-1:0] m_rexp  [NI];
    int            m_last  [NI];
    logic [DW-1:0] m_rd    [NI][2];
    logic [AW-1:0] m_raddr [NI];
    logic [DW-1:0] m_rwd   [NI];
    logic [DW-1:0] m_mem   [NI][32];

    // Requester behaviour per instance and port (0 = core, 1 = dbg).
    bit            r_req  [NI][2];
    bit            r_inf  [NI][2];
    bit            r_we   [NI][2];
    logic [AW-1:0] r_addr [NI][2];
    logic [DW-1:0] r_wd   [NI][2];
    bit            d_v    [NI][2];
    bit            d_we   [NI][2];
    logic [AW-1:0] d_addr [NI][2];
    logic [DW-1:0] d_wd   [NI][2];

    int gen_rate  = 0;
    int drop_rate = 0;
    int rst_rate  = 0;
    int prio_mode = 0;
    int first_cd  [NI];
    int first_dd  [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic queue_req(input int i, input int p, input bit we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        d_v[i][p]    = 1'b1;
        d_we[i][p]   = we;
        d_addr[i][p] = addr;
        d_wd[i][p]   = wd;
    endtask

    task automatic step();
        bit    e_busy, e_we;
        bit    e_dn [2];
        int    lat;
        int    w;
        string t;
        cyc++;
        case (prio_mode)
            0:       dbg_prio = 1'b0;
            1:       dbg_prio = 1'b1;
            default: dbg_prio = 1'($urandom);
        endcase
        for (int i = 0; i < int'(NI); i++) begin
            lat = (i == 0) ? 1 : 3;
            t   = $sformatf("i%0d c%0d", i, cyc);
            if (!rst_n[i]) begin
                m_act[i]   = 1'b0;
                m_last[i]  = 1;
                m_rd[i][0] = '0;
                m_rd[i][1] = '0;
                m_raddr[i] = '0;
                m_rwd[i]   = '0;
                for (int p = 0; p < 2; p++) begin
                    r_req[i][p] = 1'b0;
                    r_inf[i][p] = 1'b0;
                end
            end
            if (m_act[i] && cyc > m_done[i]) m_act[i] = 1'b0;
            if (m_act[i] && cyc == m_start[i] + 1) begin
                m_raddr[i] = m_addr[i];
                m_rwd[i]   = m_wd[i];
            end
            if (m_act[i] && cyc == m_done[i] && !m_we[i]) m_rd[i][m_who[i]] = m_rexp[i];
            e_busy  = m_act[i] && cyc > m_start[i];
            e_we    = m_act[i] && m_we[i] && cyc == m_start[i] + 1;
            e_dn[0] = m_act[i] && m_who[i] == 0 && cyc == m_done[i];
            e_dn[1] = m_act[i] && m_who[i] == 1 && cyc == m_done[i];

            check({t, " busy"},       32'(busy[i]),       32'(e_busy));
            check({t, " ram_we"},     32'(ram_we[i]),     32'(e_we));
            check({t, " core_done"},  32'(core_done[i]),  32'(e_dn[0]));
            check({t, " dbg_done"},   32'(dbg_done[i]),   32'(e_dn[1]));
            check({t, " both_done"},  32'(core_done[i] & dbg_done[i]), 32'(0));
            check({t, " core_rdata"}, 32'(core_rdata[i]), 32'(m_rd[i][0]));
            check({t, " dbg_rdata"},  32'(dbg_rdata[i]),  32'(m_rd[i][1]));
            check({t, " ram_addr"},   32'(ram_addr[i]),   32'(m_raddr[i]));
            check({t, " ram_wdata"},  32'(ram_wdata[i]),  32'(m_rwd[i]));

            if (core_done[i] && first_cd[i] < 0) first_cd[i] = cyc;
            if (dbg_done[i] && first_dd[i] < 0)  first_dd[i] = cyc;
            if (e_we) m_mem[i][m_addr[i]] = m_wd[i];
            if (ram_we[i]) ram_mem[i][ram_addr[i]] = ram_wdata[i];

            if (!rst_n[i]) begin
                rst_n[i] = 1'b1;
            end else if (rst_rate > 0 && m_act[i] && !m_we[i] && cyc == m_start[i] + 2
                         && int'($urandom % 16) < rst_rate) begin
                rst_n[i]    = 1'b0;
                r_req[i][0] = 1'b0;
                r_req[i][1] = 1'b0;
                core_req[i] = 1'b0;
                dbg_req[i]  = 1'b0;
                continue;
            end

            for (int p = 0; p < 2; p++) begin
                if (r_inf[i][p] && e_dn[p]) begin
                    r_inf[i][p] = 1'b0;
                    r_req[i][p] = 1'b0;
                end else if (r_inf[i][p] && r_req[i][p] && cyc > m_start[i]
                             && int'($urandom % 16) < drop_rate) begin
                    r_req[i][p] = 1'b0;
                end
                if (!r_req[i][p] && !r_inf[i][p]) begin
                    if (d_v[i][p]) begin
                        d_v[i][p]    = 1'b0;
                        r_req[i][p]  = 1'b1;
                        r_we[i][p]   = d_we[i][p];
                        r_addr[i][p] = d_addr[i][p];
                        r_wd[i][p]   = d_wd[i][p];
                    end else if (int'($urandom % 8) < gen_rate) begin
                        r_req[i][p]  = 1'b1;
                        r_we[i][p]   = 1'($urandom);
                        r_addr[i][p] = AW'($urandom_range(7, 0));
                        r_wd[i][p]   = DW'($urandom);
                    end
                end
            end
            core_req[i]   = r_req[i][0];
            core_we[i]    = r_we[i][0];
            core_addr[i]  = r_addr[i][0];
            core_wdata[i] = r_wd[i][0];
            dbg_req[i]    = r_req[i][1];
            dbg_we[i]     = r_we[i][1];
            dbg_addr[i]   = r_addr[i][1];
            dbg_wdata[i]  = r_wd[i][1];

            // Model arbitration: sole requester wins; a tie goes to dbg under priority,
            // otherwise to whoever did not win last.
            if (!m_act[i] && (r_req[i][0] || r_req[i][1])) begin
                if (r_req[i][0] && r_req[i][1]) w = dbg_prio ? 1 : 1 - m_last[i];
                else                            w = r_req[i][0] ? 0 : 1;
                m_act[i]   = 1'b1;
                m_start[i] = cyc;
                m_who[i]   = w;
                m_we[i]    = r_we[i][w];
                m_addr[i]  = r_addr[i][w];
                m_wd[i]    = r_wd[i][w];
                m_done[i]  = cyc + 2 + (r_we[i][w] ? 0 : lat);
                m_rexp[i]  = m_mem[i][r_addr[i][w]];
                m_last[i]  = w;
                r_inf[i][w] = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NI); i++) begin
            for (int a = 0; a < 32; a++) begin
                ram_mem[i][a] = DW'($urandom);
                m_mem[i][a]   = ram_mem[i][a];
            end
            ram_mem[i][5] = 16'hBEEF;
            m_mem[i][5]   = 16'hBEEF;
            rst_n[i] = 1'b0;
            core_req[i] = 1'b0; core_we[i] = 1'b0; core_addr[i] = '0; core_wdata[i] = '0;
            dbg_req[i]  = 1'b0; dbg_we[i]  = 1'b0; dbg_addr[i]  = '0; dbg_wdata[i]  = '0;
            first_cd[i] = -1;
            first_dd[i] = -1;
            for (int p = 0; p < 2; p++) begin
                r_req[i][p] = 1'b0; r_inf[i][p] = 1'b0; d_v[i][p] = 1'b0;
                r_we[i][p] = 1'b0; r_addr[i][p] = '0; r_wd[i][p] = '0;
            end
            m_act[i] = 1'b0;
            m_last[i] = 1;
        end
        dbg_prio = 1'b0;
        repeat (3) @(posedge clk);

        // Core read of addr 5 straight out of reset.
        for (int i = 0; i < int'(NI); i++) queue_req(i, 0, 1'b0, AW'(5), '0);
        run(8);
        check("lat1 core read done cycle", 32'(first_cd[0]), 32'(3));
        check("lat3 core read done cycle", 32'(first_cd[1]), 32'(5));
        check("lat1 core rdata BEEF", 32'(core_rdata[0]), 32'(16'hBEEF));
        check("lat3 core rdata BEEF", 32'(core_rdata[1]), 32'(16'hBEEF));

        // Tie: dbg write wins (core won last), then core reads it back.
        for (int i = 0; i < int'(NI); i++) begin
            queue_req(i, 1, 1'b1, AW'(3), 16'h1234);
            queue_req(i, 0, 1'b0, AW'(3), '0);
        end
        run(12);
        check("lat1 dbg write done cycle", 32'(first_dd[0]), 32'(10));
        check("lat3 dbg write done cycle", 32'(first_dd[1]), 32'(10));
        check("lat1 readback 1234", 32'(core_rdata[0]), 32'(16'h1234));
        check("lat3 readback 1234", 32'(core_rdata[1]), 32'(16'h1234));

        // Core drops its req right after the grant; the read still completes.
        drop_rate = 16;
        for (int i = 0; i < int'(NI); i++) queue_req(i, 0, 1'b0, AW'(5), '0);
        run(8);
        drop_rate = 0;
        check("lat1 dropped-req rdata", 32'(core_rdata[0]), 32'(16'hBEEF));
        check("lat3 dropped-req rdata", 32'(core_rdata[1]), 32'(16'hBEEF));

        // Reset landing in WAIT.
        rst_rate = 16;
        for (int i = 0; i < int'(NI); i++) queue_req(i, 0, 1'b0, AW'(4), '0);
        run(6);
        rst_rate = 0;
        check("lat3 rdata cleared by reset", 32'(core_rdata[1]), 32'(0));

        // Continuous contention, round-robin then debug priority.
        gen_rate  = 8;
        prio_mode = 0;
        run(40);
        prio_mode = 1;
        run(40);

        // Free-running random traffic with drops and resets.
        gen_rate  = 3;
        drop_rate = 2;
        rst_rate  = 1;
        prio_mode = 2;
        run(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
